fractional_scaler_mc: RTL and testbench
=======================================

Name: fractional_scaler_mc

Overview:
Multi-channel, runtime-programmable fixed-point fractional multiplier. Each sample carries a channel tag and is scaled by that channel's active factor. The result is split into integer and fraction fields, with selectable rounding and output saturation. It sits in datapaths between sample sources and downstream resamplers/accumulators, uses valid/ready streaming handshakes, and has a 2-stage stallable pipeline.

Parameters:
CHANNELS, 4, number of independent factor channels (>=1)
IN_BIT, 8, unsigned input sample width
OUT_BIT, 6, unsigned integer output width
FRAC_BIT, 8, output fraction width
Q_BITS, 16, factor fractional bits; elaboration error if Q_BITS < FRAC_BIT
FI_BIT, 2, factor integer bits (factor range 0 to 2^FI_BIT - 2^-Q_BITS)
RESET_FACTOR, 0.5, real; quantised to FI_BIT.Q_BITS (truncated), reset value of every shadow/active factor
CH_W, max(1,$clog2(CHANNELS)), derived channel index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_wr  in  1  write factor shadow register
cfg_ch  in  CH_W  channel for cfg_wr
cfg_factor  in  FI_BIT+Q_BITS  unsigned factor, FI_BIT.Q_BITS format
cfg_commit  in  1  copy all shadow factors to active
round_mode  in  2  0 truncate, 1 round-half-up, 2 round-half-even, 3 = truncate
s_valid  in  1  input sample valid
s_ready  out  1  input accept
s_ch  in  CH_W  input channel tag
s_data  in  IN_BIT  input sample
m_valid  out  1  output valid
m_ready  in  1  downstream accept
m_ch  out  CH_W  channel tag of output
m_dout  out  OUT_BIT  integer part of result
m_frac  out  FRAC_BIT  fractional part of result
m_sat  out  1  result saturated

Behaviour:
- Reset (async, rst=1): m_valid=0, all stage valids=0, m_ch/m_dout/m_frac/m_sat=0. Every shadow and active factor = quantised RESET_FACTOR. s_ready=0 while rst high; s_ready=1 in the first cycle after release.
- Handshake: a transfer occurs when valid&&ready on the rising edge. advance = !m_valid || m_ready. Stage1 loads when !v1 || advance. s_ready = !v1 || advance (combinational). m_valid/m_* hold stable while m_valid && !m_ready.
- Stage1 registers P = s_data * active_factor[s_ch] (IN_BIT+FI_BIT+Q_BITS bits, exact). It also registers s_ch and round_mode, sampled with the data.
- Stage2 registers the rounded/saturated result. Latency is 2 cycles from accept to m_valid when unstalled. Throughput is 1 sample/clk.
- Rounding: D = Q_BITS-FRAC_BIT LSBs dropped; K = P>>D; R = P[D-1:0]; H = 2^(D-1).
  - Mode 0/3: K.
  - Mode 1: K+1 if R>=H.
  - Mode 2: K+1 if R>H, or if R==H and K[0]==1.
  - D==0: K in all modes.
  - Rounding add is done at full width (no wrap).
- Saturation: if rounded value >= 2^(OUT_BIT+FRAC_BIT), output is m_dout=all ones, m_frac=all ones, m_sat=1. Otherwise m_dout = value[FRAC_BIT +: OUT_BIT], m_frac = value[FRAC_BIT-1:0], m_sat=0.
- Factors:
  - cfg_wr writes shadow[cfg_ch] at the edge. cfg_ch >= CHANNELS is ignored.
  - cfg_commit copies all shadows to active at the edge. The commit uses shadow values from before that edge: a same-cycle cfg_wr lands in shadow only and is applied at the next commit.
  - A sample accepted in the commit cycle uses the pre-commit active factor.
  - s_ch >= CHANNELS uses channel 0's factor; the tag is passed through unchanged.
- Config ports have no handshake and are always accepted, including during stalls. Stalled in-flight samples are not recomputed.

Test Plan:
1. Defaults after reset, mode 0: din=100 ch0 -> m_dout=50, m_frac=0x00, m_sat=0, m_valid exactly 2 cycles after accept. din=101 -> m_dout=50, m_frac=0x80.
2. Rounding: factor 0x00003, din=0x80 (P=0x180, R=half, K odd) -> m_frac 0x01 (mode 0), 0x02 (mode 1), 0x02 (mode 2). Factor 0x00001, din=0x80 -> mode 2 gives 0x00, mode 1 gives 0x01.
3. Saturation: factor 1.0 (0x10000). din=64 -> m_dout=63, m_frac=0xFF, m_sat=1. din=63 -> m_dout=63, m_frac=0x00, m_sat=0. Factor 3.99998 (0x3FFFF), din=255 -> saturated.
4. Backpressure: 8 back-to-back samples with m_ready low for cycles 3-6. Required: s_ready falls once both stages are held, no loss/duplication, order and m_ch preserved, outputs stable while stalled.
5. Commit semantics: write ch2 shadow 0.25 without commit; ch2 din=100 -> 50. Commit, then ch2 din=100 -> 25 while ch0 is still 50. cfg_wr(ch1,1.0) with cfg_commit in the same cycle -> ch1 stays 0.5 until the next commit. Sample accepted in the commit cycle uses the old factor.
6. Reset mid-stream: assert rst asynchronously with m_valid=1 and stage1 full. Required: m_valid drops before the next clk edge, all factors return to 0.5, and the first post-reset sample ch3 din=100 -> 50.

Source files
------------

// File: rtl/fractional_scaler_mc.sv
// Multi-channel fixed-point fractional scaler: 2-stage stallable valid/ready pipeline with
// per-channel shadow/active factors, selectable rounding and output saturation.
module fractional_scaler_mc #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned IN_BIT       = 8,
   parameter int unsigned OUT_BIT      = 6,
   parameter int unsigned FRAC_BIT     = 8,
   parameter int unsigned Q_BITS       = 16,
   parameter int unsigned FI_BIT       = 2,
   parameter real         RESET_FACTOR = 0.5,
   parameter int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_wr_i,
   input  logic [CH_W-1:0]          cfg_ch_i,
   input  logic [FI_BIT+Q_BITS-1:0] cfg_factor_i,
   input  logic                     cfg_commit_i,
   input  logic [1:0]               round_mode_i,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   input  logic [CH_W-1:0]          s_ch_i,
   input  logic [IN_BIT-1:0]        s_data_i,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic [CH_W-1:0]          m_ch_o,
   output logic [OUT_BIT-1:0]       m_dout_o,
   output logic [FRAC_BIT-1:0]      m_frac_o,
   output logic                     m_sat_o
);

   localparam int unsigned FW = FI_BIT + Q_BITS;
   localparam int unsigned PW = IN_BIT + FW;
   localparam int unsigned D  = Q_BITS - FRAC_BIT;
   localparam int unsigned OW = OUT_BIT + FRAC_BIT;
   localparam int unsigned RW = PW - D + OW + 1;
   localparam logic [FW-1:0] RstFactor = FW'($rtoi(RESET_FACTOR * (2.0 ** Q_BITS)));

   if (Q_BITS < FRAC_BIT) begin : gen_param_check
      $error("fractional_scaler_mc: Q_BITS must be >= FRAC_BIT");
   end

   logic [FW-1:0]       shadow_q [CHANNELS];
   logic [FW-1:0]       active_q [CHANNELS];
   logic [FW-1:0]       sel_factor;
   logic [PW-1:0]       prod;
   logic                v1_q;
   logic [PW-1:0]       p1_q;
   logic [CH_W-1:0]     ch1_q;
   logic [1:0]          mode1_q;
   logic                m_valid_q, m_sat_q, sat_d;
   logic [CH_W-1:0]     m_ch_q;
   logic [OUT_BIT-1:0]  m_dout_q, dout_d;
   logic [FRAC_BIT-1:0] m_frac_q, frac_d;
   logic [RW-1:0]       rnd_val;
   logic                advance, ld1;

   assign advance   = !m_valid_q || m_ready_i;
   assign ld1       = !v1_q || advance;
   assign s_ready_o = ld1 && !rst;

   // Commit reads pre-edge shadows, so a same-cycle write waits for the next commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= RstFactor;
            active_q[i] <= RstFactor;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_commit_i) active_q[i] <= shadow_q[i];
            if (cfg_wr_i && (int'(cfg_ch_i) == i)) shadow_q[i] <= cfg_factor_i;
         end
      end
   end

   // Out-of-range tags fall back to channel 0's factor.
   always_comb begin
      sel_factor = active_q[0];
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(s_ch_i) == i) sel_factor = active_q[i];
      end
   end

   assign prod = PW'(s_data_i) * PW'(sel_factor);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         p1_q    <= '0;
         ch1_q   <= '0;
         mode1_q <= '0;
      end else if (ld1) begin
         v1_q <= s_valid_i;
         if (s_valid_i) begin
            p1_q    <= prod;
            ch1_q   <= s_ch_i;
            mode1_q <= round_mode_i;
         end
      end
   end

   if (D == 0) begin : gen_round_none
      assign rnd_val = RW'(p1_q);
   end else begin : gen_round
      localparam logic [D-1:0] Half = D'(1) << (D - 1);
      logic [PW-D-1:0] kept;
      logic [D-1:0]    rem;
      logic            inc;

      always_comb begin
         kept = p1_q[PW-1:D];
         rem  = p1_q[D-1:0];
         inc  = 1'b0;
         unique case (mode1_q)
            2'd1:    inc = (rem >= Half);
            2'd2:    inc = (rem > Half) || ((rem == Half) && kept[0]);
            default: inc = 1'b0;
         endcase
         rnd_val = RW'(kept) + RW'(inc);
      end
   end

   always_comb begin
      sat_d  = |rnd_val[RW-1:OW];
      dout_d = sat_d ? '1 : rnd_val[FRAC_BIT +: OUT_BIT];
      frac_d = sat_d ? '1 : rnd_val[FRAC_BIT-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_ch_q    <= '0;
         m_dout_q  <= '0;
         m_frac_q  <= '0;
         m_sat_q   <= 1'b0;
      end else if (advance) begin
         m_valid_q <= v1_q;
         if (v1_q) begin
            m_ch_q   <= ch1_q;
            m_dout_q <= dout_d;
            m_frac_q <= frac_d;
            m_sat_q  <= sat_d;
         end
      end
   end

   assign m_valid_o = m_valid_q;
   assign m_ch_o    = m_ch_q;
   assign m_dout_o  = m_dout_q;
   assign m_frac_o  = m_frac_q;
   assign m_sat_o   = m_sat_q;

endmodule

// File: tb/tb_fractional_scaler_mc.sv
// Self-checking bench for fractional_scaler_mc: directed cases plus randomized traffic checked
// against an arithmetic reference model with an expected-output queue.
module tb_fractional_scaler_mc;

   localparam int Ch = 4;
   localparam longint RstF = 'h08000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_wr = 1'b0, cfg_commit = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [17:0] cfg_factor = '0;
   logic [1:0]  round_mode = '0;
   logic        s_valid = 1'b0, s_ready;
   logic [1:0]  s_ch = '0;
   logic [7:0]  s_data = '0;
   logic        m_valid, m_ready = 1'b1, m_sat;
   logic [1:0]  m_ch;
   logic [5:0]  m_dout;
   logic [7:0]  m_frac;

   fractional_scaler_mc #(
      .CHANNELS(4), .IN_BIT(8), .OUT_BIT(6), .FRAC_BIT(8), .Q_BITS(16), .FI_BIT(2),
      .RESET_FACTOR(0.5)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_wr_i(cfg_wr), .cfg_ch_i(cfg_ch), .cfg_factor_i(cfg_factor),
      .cfg_commit_i(cfg_commit), .round_mode_i(round_mode),
      .s_valid_i(s_valid), .s_ready_o(s_ready), .s_ch_i(s_ch), .s_data_i(s_data),
      .m_valid_o(m_valid), .m_ready_i(m_ready), .m_ch_o(m_ch), .m_dout_o(m_dout),
      .m_frac_o(m_frac), .m_sat_o(m_sat)
   );

   always #5 clk = ~clk;

   typedef struct {int ch; int dout; int frac; int sat;} exp_t;
   exp_t   exp_q[$];
   longint sh_m[Ch], act_m[Ch];
   int     n_cmp = 0, n_err = 0, n_out = 0;
   bit     watch = 0, saw_low = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Result = value * factor / 2^16, expressed in 1/256 units, rounded then clamped.
   function automatic exp_t model(int ch, int d, int mode);
      exp_t   e;
      longint p = longint'(d) * act_m[(ch < Ch) ? ch : 0];
      longint k = p / 256;
      longint r = p % 256;
      longint v = k;
      if (mode == 1 && r >= 128) v = k + 1;
      if (mode == 2 && (r > 128 || (r == 128 && (k % 2) == 1))) v = k + 1;
      e.ch = ch;
      if (v >= 16384) begin
         e.dout = 63; e.frac = 255; e.sat = 1;
      end else begin
         e.dout = int'(v / 256); e.frac = int'(v % 256); e.sat = 0;
      end
      return e;
   endfunction

   // Observes the values that the coming rising edge will act on.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < Ch; i++) begin
            sh_m[i]  = RstF;
            act_m[i] = RstF;
         end
      end else begin
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_output", 1, 0);
            end else begin
               check_eq("out_ch", m_ch, exp_q[0].ch);
               check_eq("out_dout", m_dout, exp_q[0].dout);
               check_eq("out_frac", m_frac, exp_q[0].frac);
               check_eq("out_sat", m_sat, exp_q[0].sat);
               if (m_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
         if (s_valid && s_ready) exp_q.push_back(model(s_ch, s_data, round_mode));
         if (cfg_commit) for (int i = 0; i < Ch; i++) act_m[i] = sh_m[i];
         if (cfg_wr) sh_m[cfg_ch] = cfg_factor;
         if (watch && !s_ready) saw_low = 1;
      end
   end

   task automatic send(input int ch, input int d, input int mode);
      int n = 0;
      s_valid = 1'b1; s_ch = 2'(ch); s_data = 8'(d); round_mode = 2'(mode);
      @(negedge clk);
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_eq("send_timeout", 1, 0);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic cfg(input int ch, input longint f, input bit wr, input bit commit);
      cfg_wr = wr; cfg_ch = 2'(ch); cfg_factor = 18'(f); cfg_commit = commit;
      @(posedge clk); #1;
      cfg_wr = 1'b0; cfg_commit = 1'b0;
   endtask

   task automatic set_factor(input int ch, input longint f);
      cfg(ch, f, 1, 0);
      cfg(0, 0, 0, 1);
   endtask

   task automatic one(input int ch, input int d, input int mode, input int ed, input int ef,
                      input int es, input string tag);
      send(ch, d, mode);
      @(negedge clk);
      check_eq({tag, "_lat1"}, m_valid, 0);
      @(negedge clk);
      check_eq({tag, "_lat2"}, m_valid, 1);
      check_eq({tag, "_dout"}, m_dout, ed);
      check_eq({tag, "_frac"}, m_frac, ef);
      check_eq({tag, "_sat"}, m_sat, es);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      m_ready = 1'b1;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      check_eq({tag, "_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int base;
      #12;
      check_eq("rst_mvalid", m_valid, 0);
      check_eq("rst_sready", s_ready, 0);
      check_eq("rst_dout", {m_ch, m_dout, m_frac, m_sat}, 0);
      rst = 1'b0;
      #1 check_eq("rst_release_sready", s_ready, 1);
      @(posedge clk); #1;

      one(0, 100, 0, 50, 'h00, 0, "t1_100");
      one(0, 101, 0, 50, 'h80, 0, "t1_101");

      set_factor(0, 'h00003);
      one(0, 'h80, 0, 0, 'h01, 0, "t2_f3_m0");
      one(0, 'h80, 1, 0, 'h02, 0, "t2_f3_m1");
      one(0, 'h80, 2, 0, 'h02, 0, "t2_f3_m2");
      one(0, 'h80, 3, 0, 'h01, 0, "t2_f3_m3");
      set_factor(0, 'h00001);
      one(0, 'h80, 2, 0, 'h00, 0, "t2_f1_m2");
      one(0, 'h80, 1, 0, 'h01, 0, "t2_f1_m1");

      set_factor(0, 'h10000);
      one(0, 64, 0, 63, 'hFF, 1, "t3_64");
      one(0, 63, 0, 63, 'h00, 0, "t3_63");
      set_factor(0, 'h3FFFF);
      one(0, 255, 1, 63, 'hFF, 1, "t3_max");
      set_factor(0, RstF);

      watch = 1; saw_low = 0; base = n_out;
      fork
         for (int i = 0; i < 8; i++) send(i % Ch, int'($urandom_range(0, 255)),
                                          int'($urandom_range(0, 3)));
         begin
            repeat (2) @(posedge clk);
            #1 m_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 m_ready = 1'b1;
         end
      join
      drain("t4");
      watch = 0;
      check_eq("t4_count", n_out - base, 8);
      check_eq("t4_sready_fell", saw_low, 1);

      cfg(2, 'h04000, 1, 0);
      one(2, 100, 0, 50, 0, 0, "t5_nocommit");
      cfg(0, 0, 0, 1);
      one(2, 100, 0, 25, 0, 0, "t5_ch2");
      one(0, 100, 0, 50, 0, 0, "t5_ch0");
      cfg(1, 'h10000, 1, 1);
      one(1, 40, 0, 20, 0, 0, "t5_samecycle");
      cfg(0, 0, 0, 1);
      one(1, 40, 0, 40, 0, 0, "t5_ch1_new");
      cfg(3, 'h04000, 1, 0);
      s_valid = 1'b1; s_ch = 2'd3; s_data = 8'd100; round_mode = 2'd0; cfg_commit = 1'b1;
      #1 check_eq("t5_cc_sready", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0; cfg_commit = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("t5_cc_old", m_dout, 50);
      @(posedge clk); #1;
      one(3, 100, 0, 25, 0, 0, "t5_ch3_new");

      send(0, 100, 0);
      send(1, 100, 0);
      check_eq("t6_pre_mvalid", m_valid, 1);
      #1 rst = 1'b1;
      #1 check_eq("t6_mvalid", m_valid, 0);
      check_eq("t6_sready", s_ready, 0);
      check_eq("t6_outs", {m_ch, m_dout, m_frac, m_sat}, 0);
      @(posedge clk); #2 rst = 1'b0;
      #1 check_eq("t6_sready_rel", s_ready, 1);
      @(posedge clk); #1;
      one(3, 100, 0, 50, 0, 0, "t6_ch3");
      one(2, 100, 0, 50, 0, 0, "t6_ch2");

      for (int c = 0; c < 400; c++) begin
         s_valid    = 1'($urandom_range(0, 1));
         s_ch       = 2'($urandom_range(0, 3));
         s_data     = 8'($urandom_range(0, 255));
         round_mode = 2'($urandom_range(0, 3));
         m_ready    = ($urandom_range(0, 3) != 0);
         cfg_wr     = ($urandom_range(0, 7) == 0);
         cfg_ch     = 2'($urandom_range(0, 3));
         cfg_factor = 18'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 'h3FFFF : 'h0FFFF));
         cfg_commit = ($urandom_range(0, 9) == 0);
         @(posedge clk); #1;
      end
      s_valid = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0;
      drain("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
